add_rs_scheduler: RTL

//  Control and scheduling for a bank of NUM_RS ADD reservation-station entries.
//  - Allocates a free entry to each dispatched instruction.
//  - Snoops the CDB and raises per-entry operand-capture strobes.
//  - Tracks entry age and issues the oldest ready entry to the single ADD functional unit

---
 rtl/add_rs_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/add_rs_scheduler.sv
// rtl/add_rs_scheduler.sv - allocation, CDB snoop and age-ordered issue control for the ADD reservation stations
module add_rs_scheduler #(
    parameter int NUM_RS    = 3,
    parameter int TAG_WIDTH = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [TAG_WIDTH-1:0]          alloc_Qj_i,
    input  logic [TAG_WIDTH-1:0]          alloc_Qk_i,
    input  logic                          alloc_Vj_valid_i,
    input  logic                          alloc_Vk_valid_i,
    output logic                          alloc_fwd_j_o,
    output logic                          alloc_fwd_k_o,
    output logic [NUM_RS-1:0]             alloc_ld_o,
    input  logic [NUM_RS*TAG_WIDTH-1:0]   rs_Qj_i,
    input  logic [NUM_RS*TAG_WIDTH-1:0]   rs_Qk_i,
    input  logic [NUM_RS-1:0]             rs_Vj_valid_i,
    input  logic [NUM_RS-1:0]             rs_Vk_valid_i,
    input  logic                          cdb_valid_i,
    input  logic [TAG_WIDTH-1:0]          cdb_tag_i,
    output logic [NUM_RS-1:0]             cap_j_o,
    output logic [NUM_RS-1:0]             cap_k_o,
    output logic [NUM_RS-1:0]             busy_ld_o,
    output logic [NUM_RS-1:0]             busy_val_o,
    output logic                          fu_valid_o,
    input  logic                          fu_ready_i,
    output logic [$clog2(NUM_RS)-1:0]     fu_sel_o
);
    localparam int SEL_W = $clog2(NUM_RS);

    typedef enum logic {FREE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state [NUM_RS];
    logic [NUM_RS-1:0] older [NUM_RS];
    logic [NUM_RS-1:0] older_nxt [NUM_RS];

    logic [NUM_RS-1:0] busy, ready, cand, victim_oh, issue_oh;
    logic              do_issue;

    always_comb begin
        busy      = '0;
        ready     = '0;
        cand      = '0;
        victim_oh = '0;
        fu_sel_o  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            busy[i]  = (state[i] == WAIT);
            ready[i] = busy[i] & rs_Vj_valid_i[i] & rs_Vk_valid_i[i];
        end
        // An entry is a candidate when no other ready entry is older than it.
        for (int i = 0; i < NUM_RS; i++) begin
            cand[i] = ready[i];
            for (int j = 0; j < NUM_RS; j++)
                if (ready[j] && older[j][i]) cand[i] = 1'b0;
        end
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                victim_oh    = '0;
                victim_oh[i] = 1'b1;
            end
            if (cand[i]) fu_sel_o = SEL_W'(i);
        end
    end

    assign alloc_ready_o = |(~busy);
    assign fu_valid_o    = (|ready) && !flush;
    assign do_issue      = fu_valid_o && fu_ready_i;
    assign alloc_ld_o    = (alloc_valid_i && alloc_ready_o && !flush) ? victim_oh : '0;
    assign busy_ld_o     = alloc_ld_o | issue_oh;
    assign busy_val_o    = alloc_ld_o;

    assign alloc_fwd_j_o = alloc_valid_i && cdb_valid_i && !alloc_Vj_valid_i
                           && (cdb_tag_i == alloc_Qj_i) && !flush;
    assign alloc_fwd_k_o = alloc_valid_i && cdb_valid_i && !alloc_Vk_valid_i
                           && (cdb_tag_i == alloc_Qk_i) && !flush;

    always_comb begin
        cap_j_o  = '0;
        cap_k_o  = '0;
        issue_oh = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cap_j_o[i]  = cdb_valid_i && busy[i] && !rs_Vj_valid_i[i] && !flush
                          && (rs_Qj_i[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag_i);
            cap_k_o[i]  = cdb_valid_i && busy[i] && !rs_Vk_valid_i[i] && !flush
                          && (rs_Qk_i[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag_i);
            issue_oh[i] = do_issue && (fu_sel_o == SEL_W'(i));
        end
    end

    // Issue clearing is applied last so a same-cycle alloc never marks the leaving entry older.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            for (int j = 0; j < NUM_RS; j++) begin
                older_nxt[i][j] = older[i][j];
                if (alloc_ld_o[j] && busy[i]) older_nxt[i][j] = 1'b1;
                if (alloc_ld_o[i])            older_nxt[i][j] = 1'b0;
                if (issue_oh[i] || issue_oh[j]) older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) begin
                state[i] <= FREE;
                older[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_RS; i++) begin
                state[i] <= FREE;
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (alloc_ld_o[i])    state[i] <= WAIT;
                else if (issue_oh[i]) state[i] <= FREE;
                older[i] <= older_nxt[i];
            end
        end
    end
endmodule
